// File: rtl/rank32.sv
// Lexicographic ranking of an N-element permutation streamed one row per column.
// Define RANK32_CHECK_EN to flag out-of-range or repeated rows (err, rank forced to all ones).
module rank32 #(
    parameter int unsigned N = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [5:0]  row,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] rank,
    output logic        err
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ACCEPT, DONE} state_t;

    state_t        state, state_next;
    logic [31:0]   acc, acc_next, acc_upd;
    logic [CW-1:0] col, col_next;
    logic [N-1:0]  used, used_next, below, onehot;
    logic [31:0]   rank_next;
    logic [5:0]    d;
    logic          armed, take_start, accept;

`ifdef RANK32_CHECK_EN
    logic err_r, err_next, bad;
`endif

    // start is only honoured once a clock edge has passed since reset released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            col   <= '0;
            used  <= '0;
            rank  <= '0;
            armed <= 1'b0;
`ifdef RANK32_CHECK_EN
            err_r <= 1'b0;
`endif
        end else begin
            state <= state_next;
            acc   <= acc_next;
            col   <= col_next;
            used  <= used_next;
            rank  <= rank_next;
            armed <= 1'b1;
`ifdef RANK32_CHECK_EN
            err_r <= err_next;
`endif
        end
    end

    always_comb begin
        below  = '0;
        d      = '0;
        onehot = ONE << row;
        for (int unsigned j = 0; j < N; j++) begin
            if (j < 32'(row)) below[j] = 1'b1;
            if (below[j] && !used[j]) d = d + 6'd1;
        end
        acc_upd = acc * (N - 32'(col)) + 32'(d);
    end

    always_comb begin
        take_start = start && armed;
        in_ready   = (state == ACCEPT);
        busy       = (state == ACCEPT) || (state == DONE);
        done       = (state == DONE) && !take_start;
        accept     = in_ready && in_valid;

        state_next = state;
        acc_next   = acc;
        col_next   = col;
        used_next  = used;
        rank_next  = rank;
`ifdef RANK32_CHECK_EN
        bad      = (32'(row) >= N) || ((used & onehot) != '0);
        err_next = err_r;
`endif

        if (take_start) begin
            state_next = ACCEPT;
            acc_next   = '0;
            col_next   = '0;
            used_next  = '0;
`ifdef RANK32_CHECK_EN
            err_next = 1'b0;
`endif
        end else begin
            case (state)
                ACCEPT: begin
                    if (accept) begin
                        acc_next  = acc_upd;
                        col_next  = col + 1'b1;
                        used_next = used | onehot;
`ifdef RANK32_CHECK_EN
                        err_next  = err_r || bad;
`endif
                        if (32'(col) == N - 1) begin
                            state_next = DONE;
`ifdef RANK32_CHECK_EN
                            rank_next = (err_r || bad) ? '1 : acc_upd;
`else
                            rank_next = acc_upd;
`endif
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef RANK32_CHECK_EN
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rank32.sv
// Directed bench for rank32 (N=12): vector table, unrank round trip, stall, abort and reset cases.
// Input-check cases run only when RANK32_CHECK_EN is defined.
module tb_rank32;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [5:0]  row;
    logic        in_ready, busy, done, err;
    logic [31:0] rank;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [11:0][5:0] rows;
        logic             toggle;
        logic [31:0]      exp_rank;
    } vec_t;

    vec_t vecs [6];

    rank32 #(.N(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .row      (row),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .rank     (rank),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic longint fact(input int k);
        longint f = 1;
        for (int i = 2; i <= k; i++) f = f * i;
        return f;
    endfunction

    function automatic logic [11:0][5:0] unrank(input longint num);
        logic [11:0][5:0] r;
        bit               taken [12];
        longint           n = num;
        for (int i = 0; i < 12; i++) taken[i] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            longint f   = fact(11 - c);
            int     idx = int'(n / f);
            n = n % f;
            for (int v = 0; v < 12; v++) begin
                if (!taken[v]) begin
                    if (idx == 0) begin
                        r[c] = 6'(v);
                        taken[v] = 1'b1;
                        idx = -1;
                    end else if (idx > 0) begin
                        idx--;
                    end
                end
            end
        end
        return r;
    endfunction

    // Drives start, then streams the rows; lat counts edges from the start edge to the done edge inclusive.
    task automatic run_job(input logic [11:0][5:0] rows, input bit toggle,
                           output logic [31:0] r, output int lat, output int dcnt, output logic e);
        int i = 0;
        int budget = 0;
        bit phase = 1'b0;
        bit accepted;
        dcnt = 0;
        lat  = 0;
        r    = '0;
        e    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (dcnt == 0 && budget < 100) begin
            if (i < 12 && !(toggle && phase)) begin
                in_valid = 1'b1;
                row = rows[i];
            end else begin
                in_valid = 1'b0;
            end
            accepted = in_valid && in_ready;
            phase = ~phase;
            @(posedge clk); #1;
            budget++;
            lat++;
            if (accepted) i++;
            if (done) begin
                dcnt++;
                r = rank;
                e = err;
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        if (done) dcnt++;
    endtask

    logic [11:0][5:0] rv;
    logic [31:0]      r;
    int               lat, dcnt;
    logic             e;

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; row = '0;

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 12; i++) vecs[k].rows[i] = 6'(i);
            vecs[k].toggle = 1'b0;
        end
        vecs[0].exp_rank = 32'd0;
        for (int i = 0; i < 12; i++) vecs[1].rows[i] = 6'(11 - i);
        vecs[1].exp_rank = 32'd479001599;
        vecs[2].rows[10] = 6'd11; vecs[2].rows[11] = 6'd10;
        vecs[2].toggle = 1'b1;
        vecs[2].exp_rank = 32'd1;
        vecs[3].rows[0] = 6'd1; vecs[3].rows[1] = 6'd0;
        vecs[3].exp_rank = 32'd39916800;
        vecs[4].rows[9] = 6'd10; vecs[4].rows[10] = 6'd9;
        vecs[4].exp_rank = 32'd2;
        vecs[5].rows[0] = 6'd11;
        for (int i = 1; i < 12; i++) vecs[5].rows[i] = 6'(i - 1);
        vecs[5].exp_rank = 32'd439084800;

        #2;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_rank", rank, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 6; k++) begin
            run_job(vecs[k].rows, vecs[k].toggle, r, lat, dcnt, e);
            chk($sformatf("vec%0d_rank", k), r, vecs[k].exp_rank);
            chk($sformatf("vec%0d_done_pulses", k), 32'(dcnt), 32'd1);
            chk($sformatf("vec%0d_err", k), {31'd0, e}, 32'd0);
            if (!vecs[k].toggle) chk($sformatf("vec%0d_latency", k), 32'(lat), 32'd13);
            chk($sformatf("vec%0d_rank_hold", k), rank, vecs[k].exp_rank);
            chk($sformatf("vec%0d_idle_busy", k), {31'd0, busy}, 32'd0);
        end

        for (int n = 0; n <= 20; n++) begin
            rv = unrank(longint'(n));
            run_job(rv, 1'b0, r, lat, dcnt, e);
            chk($sformatf("unrank%0d_rank", n), r, 32'(n));
        end

        // abort: a partial job is restarted by start while ACCEPT is active
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd1);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; row = 6'd0;
        repeat (3) @(posedge clk);
        #1;
`ifdef RANK32_CHECK_EN
        chk("abort_err_before", {31'd0, err}, 32'd1);
`endif
        in_valid = 1'b0;
        run_job(vecs[0].rows, 1'b0, r, lat, dcnt, e);
        chk("abort_rank", r, 32'd0);
        chk("abort_done_pulses", 32'(dcnt), 32'd1);
        chk("abort_err_cleared", {31'd0, e}, 32'd0);

`ifdef RANK32_CHECK_EN
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        in_valid = 1'b1; row = 6'd0;
        @(posedge clk); #1;
        chk("dup_err_after_1st", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        chk("dup_err_after_2nd", {31'd0, err}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("dup_done", {31'd0, done}, 32'd1);
        chk("dup_rank", rank, 32'hFFFFFFFF);
        @(posedge clk); #1;
        rv = vecs[0].rows;
        rv[3] = 6'd12;
        run_job(rv, 1'b0, r, lat, dcnt, e);
        chk("range_rank", r, 32'hFFFFFFFF);
        chk("range_err", {31'd0, e}, 32'd1);
`endif

        // reset mid-job: rank is nonzero from the previous job
        run_job(vecs[5].rows, 1'b0, r, lat, dcnt, e);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            row = 6'(i);
            @(posedge clk); #1;
        end
        #2; rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mid_err", {31'd0, err}, 32'd0);
        chk("rst_mid_rank", rank, 32'd0);
        in_valid = 1'b0;
        @(negedge clk); rst = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("start_ignored_after_rst", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (done) chk("no_done_after_rst", {31'd0, done}, 32'd0);
        end
        run_job(vecs[3].rows, 1'b0, r, lat, dcnt, e);
        chk("post_rst_rank", r, 32'd39916800);
        chk("post_rst_done_pulses", 32'(dcnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
